// File: rtl/dispensador_vuelto_if.sv
// Change-dispenser request/status bundle.
// Controller drives start/amount; dispenser returns coins and status.
interface dispensador_vuelto_if;
  logic       start;
  logic [7:0] amount;
  logic       coin500;
  logic       coin100;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] n500;
  logic [3:0] n100;

  modport master (
    output start, amount,
    input  coin500, coin100, busy, done, err, n500, n100
  );

  modport slave (
    input  start, amount,
    output coin500, coin100, busy, done, err, n500, n100
  );
endinterface

// File: rtl/dispensador_vuelto.sv
// Change dispenser: pays 500 coins first, then 100 coins,
// as timed eject pulses separated by idle gaps.
module dispensador_vuelto #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int MAX_AMOUNT   = 11
) (
  input  logic clk,
  input  logic rst,
  dispensador_vuelto_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SEL, PAY500, PAY100, GAP, DONE
  } state_t;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST =
    8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0] MAX_AMT = 8'(MAX_AMOUNT);

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] n500_q, n500_d;
  logic [3:0] n100_q, n100_d;
  logic       err_q, err_d;

  // State and datapath registers; reset aborts any payout at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      n500_q  <= '0;
      n100_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      n500_q  <= n500_d;
      n100_q  <= n100_d;
      err_q   <= err_d;
    end
  end

  // Next-state: pick denomination, time pulse and gap, finish.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    n500_d  = n500_q;
    n100_d  = n100_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.amount <= MAX_AMT) begin
            rem_d   = bus.amount;
            n500_d  = '0;
            n100_d  = '0;
            cnt_d   = '0;
            state_d = SEL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEL: begin
        cnt_d = '0;
        if (rem_q >= 8'd5) begin
          rem_d   = rem_q - 8'd5;
          n500_d  = n500_q + 4'd1;
          state_d = PAY500;
        end else if (rem_q >= 8'd1) begin
          rem_d   = rem_q - 8'd1;
          n100_d  = n100_q + 4'd1;
          state_d = PAY100;
        end else begin
          state_d = DONE;
        end
      end
      PAY500, PAY100: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : SEL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = SEL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.coin500 = (state_q == PAY500);
  assign bus.coin100 = (state_q == PAY100);
  assign bus.busy    = (state_q == SEL) || (state_q == PAY500) ||
                       (state_q == PAY100) || (state_q == GAP);
  assign bus.done    = (state_q == DONE);
  assign bus.err     = err_q;
  assign bus.n500    = n500_q;
  assign bus.n100    = n100_q;

endmodule

// File: tb/tb_dispensador_vuelto.sv
// Directed bench for dispensador_vuelto: per-cycle output traces
// compared against hand-derived bit masks (bit c = cycle c).
module tb_dispensador_vuelto;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  dispensador_vuelto_if bus ();

  dispensador_vuelto #(
    .PULSE_CYCLES(2),
    .GAP_CYCLES(1),
    .MAX_AMOUNT(11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Drives start in "cycle 0", then samples
  // cycles 1..ncyc; start may be re-pulsed in cycles set in inj.
  task automatic run(input logic [7:0] amt,
                     input int ncyc,
                     input logic [31:0] inj,
                     input logic [7:0] inj_amt,
                     output logic [31:0] m5,
                     output logic [31:0] m1,
                     output logic [31:0] md,
                     output logic [31:0] mb,
                     output logic [31:0] me,
                     output int ovl);
    m5 = '0; m1 = '0; md = '0; mb = '0; me = '0; ovl = 0;
    bus.start  = 1'b1;
    bus.amount = amt;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      m5[c] = bus.coin500;
      m1[c] = bus.coin100;
      md[c] = bus.done;
      mb[c] = bus.busy;
      me[c] = bus.err;
      if (bus.coin500 && bus.coin100) ovl++;
      bus.start  = inj[c];
      bus.amount = inj[c] ? inj_amt : amt;
    end
    bus.start = 1'b0;
  endtask

  logic [31:0] m5, m1, md, mb, me;
  int ovl;

  initial begin
    bus.start  = 1'b0;
    bus.amount = '0;

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("rst_coin500", 32'(bus.coin500), 32'd0);
    check("rst_coin100", 32'(bus.coin100), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done_err", {bus.done, bus.err}, 32'd0);
    check("rst_counts", {bus.n500, bus.n100}, 32'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // amount=6: 500 at 2-3, 100 at 6-7, done at 10
    run(8'd6, 10, 32'd0, 8'd0, m5, m1, md, mb, me, ovl);
    check("a6_coin500", m5, 32'h0000_000C);
    check("a6_coin100", m1, 32'h0000_00C0);
    check("a6_done", md, 32'h0000_0400);
    check("a6_busy", mb, 32'h0000_03FE);
    check("a6_n500", 32'(bus.n500), 32'd1);
    check("a6_n100", 32'(bus.n100), 32'd1);
    @(negedge clk);

    // amount=11: two 500s then one 100, done at 14
    run(8'd11, 14, 32'd0, 8'd0, m5, m1, md, mb, me, ovl);
    check("a11_coin500", m5, 32'h0000_00CC);
    check("a11_coin100", m1, 32'h0000_0C00);
    check("a11_done", md, 32'h0000_4000);
    check("a11_busy", mb, 32'h0000_3FFE);
    check("a11_overlap", 32'(ovl), 32'd0);
    check("a11_n500", 32'(bus.n500), 32'd2);
    check("a11_n100", 32'(bus.n100), 32'd1);
    @(negedge clk);

    // amount=12: rejected, one-cycle err, counts kept
    run(8'd12, 4, 32'd0, 8'd0, m5, m1, md, mb, me, ovl);
    check("a12_err", me, 32'h0000_0002);
    check("a12_busy", mb, 32'd0);
    check("a12_coins", m5 | m1 | md, 32'd0);
    check("a12_n500", 32'(bus.n500), 32'd2);
    check("a12_n100", 32'(bus.n100), 32'd1);

    // amount=0: done at cycle 2, no coins
    run(8'd0, 3, 32'd0, 8'd0, m5, m1, md, mb, me, ovl);
    check("a0_done", md, 32'h0000_0004);
    check("a0_busy", mb, 32'h0000_0002);
    check("a0_coins", m5 | m1, 32'd0);
    check("a0_counts", {bus.n500, bus.n100}, 32'd0);

    // amount=9 with starts injected mid-payout and in DONE
    run(8'd9, 23, 32'h0040_0020, 8'd3, m5, m1, md, mb, me, ovl);
    check("a9_coin500", m5, 32'h0000_000C);
    check("a9_coin100", m1, 32'h000C_CCC0);
    check("a9_done", md, 32'h0040_0000);
    check("a9_busy", mb, 32'h003F_FFFE);
    check("a9_n500", 32'(bus.n500), 32'd1);
    check("a9_n100", 32'(bus.n100), 32'd4);

    // start in the IDLE cycle right after done is accepted
    run(8'd1, 6, 32'd0, 8'd0, m5, m1, md, mb, me, ovl);
    check("a1_coin100", m1, 32'h0000_000C);
    check("a1_coin500", m5, 32'd0);
    check("a1_done", md, 32'h0000_0040);
    check("a1_counts", {bus.n500, bus.n100}, 32'h0000_0001);
    @(negedge clk);

    // amount=10, reset while coin500 is high
    bus.start  = 1'b1;
    bus.amount = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("a10_coin500_on", 32'(bus.coin500), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("a10_rst_coin500", 32'(bus.coin500), 32'd0);
    check("a10_rst_busy", 32'(bus.busy), 32'd0);
    check("a10_rst_counts", {bus.n500, bus.n100}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("a10_idle", 32'(bus.busy), 32'd0);

    run(8'd1, 6, 32'd0, 8'd0, m5, m1, md, mb, me, ovl);
    check("post_coin100", m1, 32'h0000_000C);
    check("post_coin500", m5, 32'd0);
    check("post_done", md, 32'h0000_0040);
    check("post_counts", {bus.n500, bus.n100}, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dispensador_vuelto.md
Name: dispensador_vuelto

Overview:
Change-dispensing stage directly downstream of the coffee machine top level. It consumes the change amount (in units of 100) when the FSM signals a completed sale, and pays it out as a timed sequence of coin-eject pulses. The largest coin denomination is paid first: 500 coins, then 100 coins. It runs on the same slow system clock as the machine and reports busy, done and error status back to the controller.

Parameters:
PULSE_CYCLES, 2, cycles each coin-eject output stays high (>=1)
GAP_CYCLES, 1, idle cycles between consecutive coin pulses (0 allowed = no gap)
MAX_AMOUNT, 11, largest legal change request in units of 100 (1100)

Ports:
clk  in  1  system clock (driven from the 1 Hz divided clock in the machine)
rst  in  1  asynchronous, active-high reset
start  in  1  request payout; sampled each rising edge
amount  in  8  change to pay, units of 100; sampled only on an accepted start
coin500  out  1  eject one 500 coin while high
coin100  out  1  eject one 100 coin while high
busy  out  1  payout in progress
done  out  1  one-cycle pulse when payout completes
err  out  1  one-cycle pulse when a request is rejected
n500  out  4  500 coins ejected in the current/last payout
n100  out  4  100 coins ejected in the current/last payout

Behaviour:
- Reset (async, immediate, also mid-payout):
  - state IDLE.
  - All outputs 0.
  - Internal remaining and pulse/gap counters cleared.
  - Coin pulses in progress are cut off.
- All outputs are registered (Moore, decoded from state/registers). No combinational path from inputs to outputs.
- States: IDLE, SEL, PAY500, PAY100, GAP, DONE.
- IDLE:
  - busy=0.
  - start=1 and amount<=MAX_AMOUNT: latch rem=amount, clear n500/n100, go to SEL. busy=1 from the next cycle.
  - start=1 and amount>MAX_AMOUNT: stay in IDLE, err=1 for exactly the next cycle, n500/n100 unchanged.
- SEL (busy=1, one cycle):
  - rem>=5: rem<=rem-5, n500++, go to PAY500.
  - else rem>=1: rem<=rem-1, n100++, go to PAY100.
  - else go to DONE.
- PAY500 / PAY100:
  - The matching coin output is high for exactly PULSE_CYCLES consecutive cycles.
  - Then go to GAP if GAP_CYCLES>0, else go to SEL.
  - coin500 and coin100 are never high in the same cycle.
- GAP: both coins low for exactly GAP_CYCLES cycles, then go to SEL.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - A start arriving in the DONE cycle is ignored.
  - A start in the following cycle (IDLE) is accepted.
- start while busy=1 or in DONE: ignored. amount is not re-sampled.
- amount=0: start → SEL → DONE. done is high 2 cycles after the start edge, with no coin pulses and n500=n100=0.
- Timing formula:
  - cycles from start edge to done = 1 + k*(1+PULSE_CYCLES+GAP_CYCLES) + 1, where k = coins paid = amount/5 + amount%5.
  - Example, amount=6, defaults: coin500 high cycles 2–3, coin100 high cycles 6–7, done at cycle 10 (cycle 1 = first cycle after the start edge).
- n500/n100 hold their final values after DONE until the next accepted start or reset.
- Arithmetic: rem is 8-bit unsigned. Subtraction only happens under the >= guard, so rem never wraps.

Test Plan:
1. rst pulse mid-cycle, no clk edge → all outputs 0 immediately; after release start=0 keeps busy=0.
2. start with amount=6, defaults → coin500 high cycles 2–3, coin100 high cycles 6–7, done cycle 10, n500=1, n100=1, busy low in cycle 10.
3. amount=11 → two 500 pulses then one 100 pulse, never overlapping; n500=2, n100=1; done at cycle 14.
4. amount=12 → err=1 for one cycle, busy stays 0, no coin pulses, n500/n100 keep previous values. amount=0 → done at cycle 2, no coins.
5. amount=9, then start with amount=3 asserted during the payout → ignored; total 1×500 + 4×100, n100=4. A start in the cycle after done is accepted.
6. rst asserted while coin500 is high in amount=10 → coin500 drops immediately, IDLE. A new start with amount=1 gives a single coin100 pulse and n500=0.
